// File: rtl/sweep_sequencer.sv
// Front-end sweep sequencer: steps through a code table, settling then dwelling for N samples per step.
// Define SWEEP_LOOP_EN to allow continuous sweeping via control bit2.
module sweep_sequencer #(
  parameter logic [6:0] BASE   = 7'd80,
  parameter int         NSTEPS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        serial_strobe,
  input  logic [6:0]  serial_addr,
  input  logic [31:0] serial_data,
  input  logic        sample_strobe,
  output logic [5:0]  fe_ctrl,
  output logic        enable_rx,
  output logic        busy,
  output logic [3:0]  step_idx,
  output logic        sweep_done,
  output logic [31:0] status
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    DWELL  = 3'd3,
    NEXT   = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  stepIdx_q, stepIdx_d;
  logic [5:0]  feCtrl_q, feCtrl_d;
  logic [23:0] cnt_q, cnt_d;
  logic        sweepDone_q, sweepDone_d;
  logic [23:0] settleCycles_q, settleCycles_d;
  logic [23:0] dwellSamples_q, dwellSamples_d;
  logic [4:0]  numSteps_q, numSteps_d;
  logic        loop_q, loop_d;
  logic [5:0]  stepTable_q [16];

  logic       ctrlWr, startCmd, abortCmd, tableWr;
  logic [4:0] effSteps, lastIdx;
  logic       unusedData;

  assign ctrlWr   = serial_strobe && (serial_addr == BASE);
  assign startCmd = ctrlWr && serial_data[0] && !serial_data[1];
  assign abortCmd = ctrlWr && serial_data[1];
  assign tableWr  = serial_strobe && (serial_addr == BASE + 7'd3)
                    && ({28'd0, serial_data[19:16]} < NSTEPS);
  assign unusedData = ^serial_data[31:24];

  assign effSteps = (numSteps_q == 5'd0) ? 5'd1 :
                    (numSteps_q > 5'(NSTEPS)) ? 5'(NSTEPS) : numSteps_q;
  assign lastIdx  = effSteps - 5'd1;

  always_comb begin
    settleCycles_d = settleCycles_q;
    dwellSamples_d = dwellSamples_q;
    numSteps_d     = numSteps_q;
    loop_d         = loop_q;
    if (serial_strobe && (serial_addr == BASE + 7'd1)) settleCycles_d = serial_data[23:0];
    if (serial_strobe && (serial_addr == BASE + 7'd2)) dwellSamples_d = serial_data[23:0];
    if (serial_strobe && (serial_addr == BASE + 7'd4)) numSteps_d = serial_data[4:0];
`ifdef SWEEP_LOOP_EN
    if (ctrlWr) loop_d = serial_data[2];
`else
    loop_d = 1'b0;
`endif
  end

  // Table entries above NSTEPS are never written, so they stay at their reset value.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) stepTable_q[i] <= 6'd0;
    end else if (tableWr) begin
      stepTable_q[serial_data[19:16]] <= serial_data[5:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    stepIdx_d   = stepIdx_q;
    feCtrl_d    = feCtrl_q;
    cnt_d       = cnt_q;
    sweepDone_d = 1'b0;
    if (abortCmd) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (startCmd) begin
            state_d   = APPLY;
            stepIdx_d = 4'd0;
          end
        end
        APPLY: begin
          feCtrl_d = stepTable_q[stepIdx_q];
          cnt_d    = settleCycles_q;
          state_d  = SETTLE;
        end
        SETTLE: begin
          if (cnt_q <= 24'd1) begin
            cnt_d   = (dwellSamples_q == 24'd0) ? 24'd1 : dwellSamples_q;
            state_d = DWELL;
          end else begin
            cnt_d = cnt_q - 24'd1;
          end
        end
        DWELL: begin
          if (sample_strobe) begin
            cnt_d = cnt_q - 24'd1;
            if (cnt_q <= 24'd1) begin
              cnt_d   = 24'd0;
              state_d = NEXT;
            end
          end
        end
        NEXT: begin
          if ({1'b0, stepIdx_q} < lastIdx) begin
            stepIdx_d = stepIdx_q + 4'd1;
            state_d   = APPLY;
          end else begin
            sweepDone_d = 1'b1;
            if (loop_q) begin
              stepIdx_d = 4'd0;
              state_d   = APPLY;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      stepIdx_q      <= 4'd0;
      feCtrl_q       <= 6'd0;
      cnt_q          <= 24'd0;
      sweepDone_q    <= 1'b0;
      settleCycles_q <= 24'd0;
      dwellSamples_q <= 24'd0;
      numSteps_q     <= 5'd1;
      loop_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      stepIdx_q      <= stepIdx_d;
      feCtrl_q       <= feCtrl_d;
      cnt_q          <= cnt_d;
      sweepDone_q    <= sweepDone_d;
      settleCycles_q <= settleCycles_d;
      dwellSamples_q <= dwellSamples_d;
      numSteps_q     <= numSteps_d;
      loop_q         <= loop_d;
    end
  end

  assign fe_ctrl    = feCtrl_q;
  assign enable_rx  = (state_q == DWELL);
  assign busy       = (state_q != IDLE);
  assign step_idx   = stepIdx_q;
  assign sweep_done = sweepDone_q;
  assign status     = {busy, state_q, stepIdx_q, 8'd0,
                       (state_q == DWELL) ? cnt_q[15:0] : 16'd0};

endmodule

// File: tb/tb_sweep_sequencer.sv
// Self-checking bench for sweep_sequencer: table-driven sweeps plus hand-written abort/reset/loop sequences.
// Compile with SWEEP_LOOP_EN defined to exercise continuous sweeping.
`timescale 1ns/1ps
module tb_sweep_sequencer;

  localparam logic [6:0] BASE   = 7'd80;
  localparam int         NSTEPS = 8;

  logic        clock, reset, serial_strobe, sample_strobe;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic [5:0]  fe_ctrl;
  logic        enable_rx, busy, sweep_done;
  logic [3:0]  step_idx;
  logic [31:0] status;

  typedef struct {
    logic [3:0] idx;
    logic [5:0] fe;
    int         strobes;
    int         settle;
  } exp_t;

  typedef struct {
    logic [4:0] numSteps;
    int         settle;
    int         dwell;
    int         period;
    int         expSteps;
  } vec_t;

  exp_t       expQ[$];
  exp_t       cur;
  vec_t       vecs[4];
  logic [5:0] tableVal [8];

  int checks = 0;
  int fails = 0;
  int doneCount = 0;
  int strobeCnt = 0;
  int settleCnt = 0;
  int strobePeriod = 5;
  int doneBefore;
  logic prevEn = 1'b0;

  sweep_sequencer #(.BASE(BASE), .NSTEPS(NSTEPS)) dut (
    .clock(clock), .reset(reset),
    .serial_strobe(serial_strobe), .serial_addr(serial_addr), .serial_data(serial_data),
    .sample_strobe(sample_strobe),
    .fe_ctrl(fe_ctrl), .enable_rx(enable_rx), .busy(busy), .step_idx(step_idx),
    .sweep_done(sweep_done), .status(status)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Sample strobes change just after the rising edge so the negedge monitor sees them stable.
  initial begin
    int phase;
    phase = 0;
    sample_strobe = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      phase++;
      if (phase >= strobePeriod) begin
        phase = 0;
        sample_strobe = 1'b1;
      end else begin
        sample_strobe = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Called at a negedge; holds the write for exactly one rising edge.
  task automatic applyStimulus(input logic [6:0] addr, input logic [31:0] data);
    serial_strobe = 1'b1;
    serial_addr   = addr;
    serial_data   = data;
    @(negedge clock);
    serial_strobe = 1'b0;
  endtask

  function automatic int atLeastOne(input int x);
    return (x < 1) ? 1 : x;
  endfunction

  task automatic pushSteps(input int count, input int strobes, input int settle);
    exp_t e;
    for (int k = 0; k < count; k++) begin
      e.idx     = 4'(k);
      e.fe      = tableVal[k];
      e.strobes = strobes;
      e.settle  = settle;
      expQ.push_back(e);
    end
  endtask

  task automatic waitDone(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clock);
      seen = sweep_done;
    end
    checks++;
    if (!seen) begin
      fails++;
      $display("[TB] FAIL %s: sweep_done never seen within 3000 cycles", name);
    end else begin
      checkOutput({name, "_busy"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic waitStep(input logic [3:0] idx, input bit needEn, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clock);
      seen = (step_idx == idx) && (!needEn || enable_rx);
    end
    checks++;
    if (!seen) begin
      fails++;
      $display("[TB] FAIL %s: step %0d never reached within 2000 cycles", name, idx);
    end
  endtask

  // Scoreboard: each dwell window pops one expected step and checks code, index, settle length and strobe count.
  always @(negedge clock) begin
    if (enable_rx && !prevEn) begin
      checks++;
      if (expQ.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_step: dwell at step %0d with nothing expected", step_idx);
        cur.strobes = -1;
      end else begin
        cur = expQ.pop_front();
        checkOutput("step_idx", 32'(step_idx), 32'(cur.idx));
        checkOutput("step_fe", 32'(fe_ctrl), 32'(cur.fe));
        checkOutput("settle_len", 32'(settleCnt), 32'(cur.settle));
      end
      strobeCnt = 0;
    end
    if (enable_rx && sample_strobe) strobeCnt++;
    if (!enable_rx && prevEn && cur.strobes >= 0)
      checkOutput("dwell_strobes", 32'(strobeCnt), 32'(cur.strobes));
    if (status[30:28] == 3'd1) settleCnt = 0;
    if (status[30:28] == 3'd2) settleCnt++;
    if (sweep_done === 1'b1) doneCount++;
    prevEn = (enable_rx === 1'b1);
  end

  initial begin
    tableVal = '{6'h01, 6'h22, 6'h0C, 6'h15, 6'h2A, 6'h33, 6'h07, 6'h3F};
    vecs[0] = '{5'd3,  10, 4, 5, 3};
    vecs[1] = '{5'd1,  0,  0, 3, 1};
    vecs[2] = '{5'd0,  2,  1, 2, 1};
    vecs[3] = '{5'd20, 1,  2, 2, 8};
    cur = '{4'd0, 6'd0, -1, 0};

    reset = 1'b1;
    serial_strobe = 1'b0;
    serial_addr = 7'd0;
    serial_data = 32'd0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    checkOutput("rst_fe", 32'(fe_ctrl), 32'd0);
    checkOutput("rst_en", 32'(enable_rx), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_idx", 32'(step_idx), 32'd0);
    checkOutput("rst_done", 32'(sweep_done), 32'd0);
    checkOutput("rst_status", status, 32'd0);

    for (int i = 0; i < 8; i++)
      applyStimulus(BASE + 7'd3, {12'd0, 4'(i), 10'd0, tableVal[i]});
    applyStimulus(BASE + 7'd3, {12'd0, 4'd9, 10'd0, 6'h3E});

    for (int v = 0; v < 4; v++) begin
      strobePeriod = vecs[v].period;
      applyStimulus(BASE + 7'd1, 32'(vecs[v].settle));
      applyStimulus(BASE + 7'd2, 32'(vecs[v].dwell));
      applyStimulus(BASE + 7'd4, {27'd0, vecs[v].numSteps});
      doneBefore = doneCount;
      pushSteps(vecs[v].expSteps, atLeastOne(vecs[v].dwell), atLeastOne(vecs[v].settle));
      applyStimulus(BASE, 32'd1);
      checkOutput("start_busy", 32'(busy), 32'd1);
      checkOutput("start_idx", 32'(step_idx), 32'd0);
      waitDone("vec_done");
      repeat (3) @(negedge clock);
      checkOutput("vec_done_pulses", 32'(doneCount - doneBefore), 32'd1);
      checkOutput("vec_queue_empty", 32'(expQ.size()), 32'd0);
      checkOutput("vec_final_fe", 32'(fe_ctrl), 32'(tableVal[vecs[v].expSteps - 1]));
    end

    // Abort while dwelling on step 1.
    strobePeriod = 5;
    applyStimulus(BASE + 7'd1, 32'd2);
    applyStimulus(BASE + 7'd2, 32'd4);
    applyStimulus(BASE + 7'd4, 32'd3);
    pushSteps(1, 4, 2);
    expQ.push_back('{4'd1, tableVal[1], -1, 2});
    doneBefore = doneCount;
    applyStimulus(BASE, 32'd1);
    waitStep(4'd1, 1'b1, "abort_wait");
    checkOutput("dwell_status", status, 32'hB100_0004);
    repeat (3) @(negedge clock);
    applyStimulus(BASE, 32'd2);
    checkOutput("abort_state", 32'(status[30:28]), 32'd0);
    checkOutput("abort_en", 32'(enable_rx), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_fe", 32'(fe_ctrl), 32'(tableVal[1]));
    repeat (20) @(negedge clock);
    checkOutput("abort_no_done", 32'(doneCount - doneBefore), 32'd0);
    checkOutput("abort_stays_idle", 32'(busy), 32'd0);

    // Start and abort on the same strobe from IDLE.
    applyStimulus(BASE, 32'd3);
    checkOutput("startabort_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clock);
    checkOutput("startabort_state", 32'(status[30:28]), 32'd0);

    // A second start while busy must not restart the sweep.
    strobePeriod = 3;
    applyStimulus(BASE + 7'd1, 32'd3);
    applyStimulus(BASE + 7'd2, 32'd2);
    pushSteps(3, 2, 3);
    doneBefore = doneCount;
    applyStimulus(BASE, 32'd1);
    waitStep(4'd1, 1'b0, "busystart_wait");
    applyStimulus(BASE, 32'd1);
    checkOutput("busystart_idx", 32'(step_idx), 32'd1);
    waitDone("busystart_done");
    repeat (3) @(negedge clock);
    checkOutput("busystart_pulses", 32'(doneCount - doneBefore), 32'd1);
    checkOutput("busystart_queue", 32'(expQ.size()), 32'd0);

    strobePeriod = 2;
    applyStimulus(BASE + 7'd1, 32'd1);
    applyStimulus(BASE + 7'd2, 32'd1);
    applyStimulus(BASE + 7'd4, 32'd2);
    doneBefore = doneCount;
`ifdef SWEEP_LOOP_EN
    pushSteps(2, 1, 1);
    pushSteps(2, 1, 1);
    applyStimulus(BASE, 32'd5);
    for (int pass = 0; pass < 2; pass++) begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 500 && !seen; i++) begin
        @(negedge clock);
        seen = sweep_done;
      end
      checkOutput("loop_done_seen", 32'(seen), 32'd1);
      checkOutput("loop_busy", 32'(busy), 32'd1);
      checkOutput("loop_idx", 32'(step_idx), 32'd0);
    end
    applyStimulus(BASE, 32'd2);
    checkOutput("loop_abort_busy", 32'(busy), 32'd0);
    checkOutput("loop_abort_en", 32'(enable_rx), 32'd0);
    repeat (5) @(negedge clock);
    checkOutput("loop_pulses", 32'(doneCount - doneBefore), 32'd2);
    checkOutput("loop_queue", 32'(expQ.size()), 32'd0);
`else
    pushSteps(2, 1, 1);
    applyStimulus(BASE, 32'd5);
    waitDone("noloop_done");
    repeat (10) @(negedge clock);
    checkOutput("noloop_busy", 32'(busy), 32'd0);
    checkOutput("noloop_pulses", 32'(doneCount - doneBefore), 32'd1);
    checkOutput("noloop_queue", 32'(expQ.size()), 32'd0);
`endif

    // Reset in the middle of a dwell, with a start strobe on the same edge.
    applyStimulus(BASE + 7'd1, 32'd2);
    applyStimulus(BASE + 7'd2, 32'd3);
    expQ.push_back('{4'd0, tableVal[0], -1, 2});
    applyStimulus(BASE, 32'd1);
    waitStep(4'd0, 1'b1, "midreset_wait");
    reset = 1'b1;
    serial_strobe = 1'b1;
    serial_addr = BASE;
    serial_data = 32'd1;
    @(negedge clock);
    checkOutput("midreset_en", 32'(enable_rx), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_fe", 32'(fe_ctrl), 32'd0);
    checkOutput("midreset_status", status, 32'd0);
    reset = 1'b0;
    serial_strobe = 1'b0;

    // After reset: settle 0, dwell 0, one step, cleared table.
    expQ.push_back('{4'd0, 6'd0, 1, 1});
    doneBefore = doneCount;
    applyStimulus(BASE, 32'd1);
    waitDone("default_done");
    repeat (3) @(negedge clock);
    checkOutput("default_fe", 32'(fe_ctrl), 32'd0);
    checkOutput("default_pulses", 32'(doneCount - doneBefore), 32'd1);
    checkOutput("default_queue", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
